// File: rtl/seqdet_pkg.sv
// Shared helpers and default configuration constants for the programmable serial pattern detector.
package seqdet_pkg;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  localparam logic [3:0] PAT_1010 = 4'b1010;
  localparam int         LEN_4    = 4;

endpackage

// File: rtl/seqdet_prefix_match.sv
// Combinational longest-suffix-equals-prefix search: returns the largest k whose last k
// history bits equal the first k pattern bits, scanning from the longest candidate down.
module seqdet_prefix_match
  import seqdet_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int LEN_W = len_w(PAT_W)
) (
  input  logic [PAT_W-1:0] h_next,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             allow_full,
  input  logic             single_bit,
  output logic [LEN_W-1:0] next_state
);

  localparam int EXT_W = 2 ** LEN_W;

  logic [EXT_W-1:0] pat_ext_s;
  logic [LEN_W-1:0] idx_s;
  logic             hit_s;
  logic             found_s;
  logic             cand_ok_s;

  assign pat_ext_s = {{(EXT_W - PAT_W){1'b0}}, pattern};

  // Priority scan: the first (longest) admissible candidate that matches wins.
  always_comb begin
    next_state = '0;
    found_s    = 1'b0;
    hit_s      = 1'b0;
    idx_s      = '0;
    cand_ok_s  = 1'b0;
    for (int k = PAT_W; k >= 1; k--) begin
      cand_ok_s = (LEN_W'(k) <= len) && (allow_full || (LEN_W'(k) != len)) &&
                  (!single_bit || (k == 1));
      hit_s = 1'b1;
      for (int i = 0; i < PAT_W; i++) begin
        if (i < k) begin
          // history bit i (0 = newest) lines up with pattern bit len-k+i
          idx_s = len - LEN_W'(k) + LEN_W'(i);
          if (h_next[i] != pat_ext_s[idx_s]) begin
            hit_s = 1'b0;
          end else begin
            hit_s = hit_s;
          end
        end else begin
          hit_s = hit_s;
        end
      end
      if (!found_s && cand_ok_s && hit_s) begin
        next_state = LEN_W'(k);
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Moore serial pattern detector with run-time pattern, length and overlap mode.
// Optional saturating match counter enabled by defining SEQDET_CNT_EN.
module seq_detect_prog
  import seqdet_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in_bit,
  input  logic                         cfg_load,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
  input  logic                         cfg_overlap,
  output logic                         match,
  output logic [$clog2(PAT_W+1)-1:0]   state_o,
  input  logic                         cnt_clr,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int LEN_W = len_w(PAT_W);

  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             overlap_q, overlap_d;
  logic [LEN_W-1:0] state_q, state_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic             match_q, match_d;

  logic             full_s;
  logic             restart_s;
  logic             accept_s;
  logic [PAT_W-1:0] hist_src_s;
  logic [PAT_W-1:0] h_next_s;
  logic [LEN_W-1:0] pm_state_s;
  logic [LEN_W-1:0] len_clamp_s;

  assign full_s      = (len_q != {LEN_W{1'b0}}) && (state_q == len_q);
  // Non-overlap restart: forget history and never re-use the just-completed match.
  assign restart_s   = full_s && !overlap_q;
  assign accept_s    = in_valid && !cfg_load && (len_q != {LEN_W{1'b0}});
  assign hist_src_s  = restart_s ? {PAT_W{1'b0}} : hist_q;
  assign h_next_s    = {hist_src_s[PAT_W-2:0], in_bit};
  assign len_clamp_s = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;

  seqdet_prefix_match #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_prefix_match (
    .h_next     (h_next_s),
    .pattern    (pattern_q),
    .len        (len_q),
    .allow_full (!restart_s),
    .single_bit (restart_s),
    .next_state (pm_state_s)
  );

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    state_d   = state_q;
    hist_d    = hist_q;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = len_clamp_s;
      overlap_d = cfg_overlap;
      state_d   = '0;
      hist_d    = '0;
    end else if (accept_s) begin
      state_d = pm_state_s;
      hist_d  = h_next_s;
    end else begin
      state_d = state_q;
      hist_d  = hist_q;
    end
    match_d = (len_d != {LEN_W{1'b0}}) && (state_d == len_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b1;
      state_q   <= '0;
      hist_q    <= '0;
      match_q   <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      state_q   <= state_d;
      hist_q    <= hist_d;
      match_q   <= match_d;
    end
  end

  assign match   = match_q;
  assign state_o = state_q;

`ifdef SEQDET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of completed matches; clear has priority.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (accept_s && (pm_state_s == len_q) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic unused_cnt_clr_s;
  assign unused_cnt_clr_s = cnt_clr;
  assign match_cnt        = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed self-checking bench for seq_detect_prog (PAT_W=4, CNT_W=2).
module tb_seq_detect_prog;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_bit;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             match;
  logic [LEN_W-1:0] state_o;
  logic             cnt_clr;
  logic [CNT_W-1:0] match_cnt;

  int n_cmp;
  int n_err;

  seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .match       (match),
    .state_o     (state_o),
    .cnt_clr     (cnt_clr),
    .match_cnt   (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_chk(input string tag, input logic b, input int exp_state, input logic exp_match);
    step(1'b1, b);
    chk({tag, "_state"}, 32'(state_o), 32'(exp_state));
    chk({tag, "_match"}, 32'(match), 32'(exp_match));
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic ov);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_bit      = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = 4'b0000;
    cfg_len     = 3'd0;
    cfg_overlap = 1'b0;
    cnt_clr     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    rst_n = 1'b1;

    // Disabled until first load
    send_chk("pre_cfg", 1'b1, 0, 1'b0);

    // T1: 1010, overlapping
    load(4'b1010, 3'd4, 1'b1);
    chk("t1_load_state", 32'(state_o), 32'd0);
    send_chk("t1_b1", 1'b1, 1, 1'b0);
    send_chk("t1_b2", 1'b0, 2, 1'b0);
    send_chk("t1_b3", 1'b1, 3, 1'b0);
    send_chk("t1_b4", 1'b0, 4, 1'b1);
    send_chk("t1_b5", 1'b1, 3, 1'b0);
    send_chk("t1_b6", 1'b0, 4, 1'b1);

    // T2: 1010, non-overlapping
    load(4'b1010, 3'd4, 1'b0);
    clear_cnt();
    send_chk("t2_b1", 1'b1, 1, 1'b0);
    send_chk("t2_b2", 1'b0, 2, 1'b0);
    send_chk("t2_b3", 1'b1, 3, 1'b0);
    send_chk("t2_b4", 1'b0, 4, 1'b1);
    send_chk("t2_b5", 1'b1, 1, 1'b0);
    send_chk("t2_b6", 1'b0, 2, 1'b0);
    send_chk("t2_b7", 1'b1, 3, 1'b0);
    send_chk("t2_b8", 1'b0, 4, 1'b1);
`ifdef SEQDET_CNT_EN
    chk("t2_cnt", 32'(match_cnt), 32'd2);
`else
    chk("t2_cnt_tied", 32'(match_cnt), 32'd0);
`endif

    // T3: 111, overlapping
    load(4'b0111, 3'd3, 1'b1);
    send_chk("t3_b1", 1'b1, 1, 1'b0);
    send_chk("t3_b2", 1'b1, 2, 1'b0);
    send_chk("t3_b3", 1'b1, 3, 1'b1);
    send_chk("t3_b4", 1'b1, 3, 1'b1);
    send_chk("t3_b5", 1'b0, 0, 1'b0);

    // T4: hold with in_valid low keeps match
    load(4'b1010, 3'd4, 1'b1);
    send_chk("t4_b1", 1'b1, 1, 1'b0);
    send_chk("t4_b2", 1'b0, 2, 1'b0);
    send_chk("t4_b3", 1'b1, 3, 1'b0);
    send_chk("t4_b4", 1'b0, 4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      chk("t4_hold_match", 32'(match), 32'd1);
      chk("t4_hold_state", 32'(state_o), 32'd4);
    end
    send_chk("t4_b5", 1'b1, 3, 1'b0);

    // T5: asynchronous reset mid-cycle at state 3
    load(4'b1010, 3'd4, 1'b1);
    send_chk("t5_b1", 1'b1, 1, 1'b0);
    send_chk("t5_b2", 1'b0, 2, 1'b0);
    send_chk("t5_b3", 1'b1, 3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_state", 32'(state_o), 32'd0);
    chk("t5_async_match", 32'(match), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load(4'b1010, 3'd4, 1'b1);
    send_chk("t5_r1", 1'b1, 1, 1'b0);
    send_chk("t5_r2", 1'b0, 2, 1'b0);
    send_chk("t5_r3", 1'b1, 3, 1'b0);
    send_chk("t5_r4", 1'b0, 4, 1'b1);

    // T5b: cfg_load beats a same-cycle valid bit
    load(4'b1010, 3'd4, 1'b1);
    send_chk("t5c_b1", 1'b1, 1, 1'b0);
    send_chk("t5c_b2", 1'b0, 2, 1'b0);
    send_chk("t5c_b3", 1'b1, 3, 1'b0);
    in_valid = 1'b1;
    in_bit   = 1'b0;
    load(4'b1010, 3'd4, 1'b1);
    in_valid = 1'b0;
    chk("t5c_load_state", 32'(state_o), 32'd0);
    chk("t5c_load_match", 32'(match), 32'd0);
    send_chk("t5c_after0", 1'b0, 0, 1'b0);

    // Length clamp: 7 behaves as 4
    load(4'b1010, 3'd7, 1'b1);
    send_chk("clamp_b1", 1'b1, 1, 1'b0);
    send_chk("clamp_b2", 1'b0, 2, 1'b0);
    send_chk("clamp_b3", 1'b1, 3, 1'b0);
    send_chk("clamp_b4", 1'b0, 4, 1'b1);

    // Length 0 disables
    load(4'b1010, 3'd0, 1'b1);
    send_chk("len0_b1", 1'b1, 0, 1'b0);
    send_chk("len0_b2", 1'b0, 0, 1'b0);

    // T6: five matches saturate a 2-bit counter, then clear on a match edge
    load(4'b1010, 3'd4, 1'b1);
    clear_cnt();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
    end
    chk("t6_match", 32'(match), 32'd1);
`ifdef SEQDET_CNT_EN
    chk("t6_sat", 32'(match_cnt), 32'd3);
`else
    chk("t6_cnt_tied", 32'(match_cnt), 32'd0);
`endif
    step(1'b1, 1'b1);
    cnt_clr = 1'b1;
    step(1'b1, 1'b0);
    cnt_clr = 1'b0;
    chk("t6_clr_match", 32'(match), 32'd1);
    chk("t6_clr_cnt", 32'(match_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
